zxuno_uart_regbridge: RTL and testbench
=======================================

// Module: zxuno_uart_regbridge
// PURPOSE
//   Serial-to-register-bus initiator: the master end of the ZX-Uno register interface that UART peripherals respond on.
//   Receives 8N1 command frames from an external host and issues zxuno_regwr/zxuno_regrd cycles on the ZX-Uno register bus.
//   Returns an ACK, NAK or the read byte over TX. Used for bench/debug access to any register (UART, etc.) without the Z80.
// PARAMETERS
//   CLK_HZ          28000000  system clock frequency
//   BAUD            115200    serial rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit
//   BUS_CYCLES      2         clocks a read/write strobe stays asserted (>=1)
//   TIMEOUT_CYCLES  2800000   max idle clocks between bytes of one command
// PORTS
//   clk          in   1  system clock; the only clock
//   rst          in   1  synchronous, active-high reset
//   zxuno_addr   out  8  register address driven to peripherals
//   zxuno_regrd  out  1  read strobe
//   zxuno_regwr  out  1  write strobe
//   dout         out  8  write data to peripherals
//   din          in   8  read data from peripherals
//   oe_n         in   1  low = a peripheral drives din
//   uart_rx      in   1  serial in from host (asynchronous, idle high)
//   uart_tx      out  1  serial out to host (idle high)
//   uart_rts     out  1  low = host may send; high = bridge busy
// BEHAVIOUR
//   Reset: zxuno_addr=0, dout=0, zxuno_regrd=0, zxuno_regwr=0, uart_tx=1, uart_rts=1, FSM=IDLE; reset mid-op aborts it.
//   All outputs registered. uart_rts goes 0 the first cycle after rst deasserts.
//   RX: 2-flop synchronizer; falling edge starts frame; rx re-sampled at DIV/2: if high, false start, back to hunt.
//     Data bits LSB first, sampled at bit centres (every DIV clocks); stop bit sampled 1 -> byte valid (1-clk pulse).
//     Stop bit 0 -> framing error, byte discarded, FSM unaffected.
//   TX: 8N1, LSB first, each bit exactly DIV clocks; start on request only when TX idle.
//   Command protocol (bytes):
//     0x57 'W', addr, data -> write cycle; reply 0x06.
//     0x52 'R', addr       -> read cycle; reply din if oe_n=0 at sample, else 0xFF.
//     any other first byte -> reply 0x15, no bus cycle.
//   FSM: IDLE -> GET_ADDR -> [GET_DATA] -> BUS_SETUP -> BUS_STROBE -> BUS_HOLD -> SEND -> WAIT_TX -> IDLE.
//     IDLE: wait byte; W/R -> GET_ADDR, else latch 0x15 -> SEND.
//     GET_ADDR/GET_DATA: wait byte; counter reset per byte; TIMEOUT_CYCLES clocks with no byte -> IDLE, no reply, no bus cycle.
//     BUS_SETUP: 1 clk; zxuno_addr (and dout for W) updated, strobes 0.
//     BUS_STROBE: regwr or regrd =1 for exactly BUS_CYCLES clks; addr/dout stable.
//       Read: din/oe_n sampled on last strobe clock.
//     BUS_HOLD: 1 clk; strobes 0, addr/dout still held (retain until next cycle).
//     SEND: issue TX of reply byte; WAIT_TX: until stop bit fully sent, then IDLE.
//   uart_rts=0 only in IDLE/GET_ADDR/GET_DATA; bytes completing in any other state are dropped.
//   Never both strobes at once; exactly one strobe window per accepted command.
//   Byte arriving in same clock as timeout expiry: byte wins (accepted).
// TESTING (sim with CLK_HZ=1600000, BAUD=100000 -> DIV=16)
//   Send 57 FA 41 -> one regwr window of 2 clks, addr=FA dout=41, 1 clk setup/hold; TX returns 06.
//   Send 52 FB, din=80 oe_n=0 -> regrd 2 clks at addr FB, no regwr; TX returns 80.
//   Send 52 10 with oe_n=1 -> regrd window; TX returns FF.
//   Send 3F -> no strobe; TX returns 15; then 57 FA 00 works normally.
//   Send 57 FA, idle > TIMEOUT_CYCLES -> no strobe, no TX; rts low; next 52 FB served.
//   Frame with stop bit 0 -> ignored; rst during BUS_STROBE -> strobes 0, tx=1, rts=1 next clk.

Source files
------------

// File: rtl/zxuno_uart_regbridge.sv
// UART command bridge that acts as master of the ZX-Uno register bus.
// Host frames 'W' addr data / 'R' addr become bus cycles; the reply byte goes back over TX.
`timescale 1ns/1ps
module zxuno_uart_regbridge #(
  parameter int unsigned CLK_HZ         = 28000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned BUS_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2800000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] zxuno_addr,
  output logic       zxuno_regrd,
  output logic       zxuno_regwr,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       oe_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_rts
);
  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW  = $clog2(BUS_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(BUS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_SETUP, BUS_STROBE, BUS_HOLD, SEND, WAIT_TX
  } state_t;

  state_t state, state_next;

  // Receiver
  logic          rx_m, rx_s, rx_p, rx_active, rx_valid;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1; rx_s <= 1'b1; rx_p <= 1'b1;
      rx_active <= 1'b0; rx_valid <= 1'b0;
      rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_m     <= uart_rx;
      rx_s     <= rx_m;
      rx_p     <= rx_s;
      rx_valid <= 1'b0;
      if (!rx_active) begin
        if (rx_p && !rx_s) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        // half-bit check of the start bit rejects glitches
        if (rx_cnt == DIV_HALF) begin
          rx_cnt <= '0;
          if (rx_s) rx_active <= 1'b0;
          else      rx_bit    <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == DIV_LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          rx_valid  <= rx_s;
        end else begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // Transmitter
  logic          tx_busy, tx_start;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic [7:0]    reply;

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx <= 1'b1; tx_busy <= 1'b0;
      tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        uart_tx <= 1'b0;
        tx_sh   <= {1'b1, reply};
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == DIV_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        uart_tx <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_bit  <= tx_bit + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // Command datapath
  logic          is_write;
  logic [7:0]    addr_l;
  logic [TW-1:0] tmo;
  logic [SW-1:0] scnt;
  logic          is_cmd;

  assign is_cmd = (rx_sh == 8'h57) || (rx_sh == 8'h52);

  always_ff @(posedge clk) begin
    if (rst) begin
      is_write <= 1'b0; addr_l <= '0; reply <= '0; tmo <= '0; scnt <= '0;
    end else begin
      tmo  <= ((state == GET_ADDR || state == GET_DATA) && !rx_valid) ? tmo + 1'b1 : '0;
      scnt <= (state == BUS_STROBE) ? scnt + 1'b1 : '0;
      case (state)
        IDLE: if (rx_valid) begin
          is_write <= (rx_sh == 8'h57);
          if (!is_cmd) reply <= 8'h15;
        end
        GET_ADDR: if (rx_valid) addr_l <= rx_sh;
        BUS_STROBE: if (scnt == STB_LAST)
          reply <= is_write ? 8'h06 : (oe_n ? 8'hFF : din);
        default: ;
      endcase
    end
  end

  // FSM: registered outputs are loaded from the next state so they align with it
  logic [7:0] addr_d, dout_d;
  logic       regwr_d, regrd_d, rts_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      zxuno_addr <= '0; dout <= '0;
      zxuno_regwr <= 1'b0; zxuno_regrd <= 1'b0; uart_rts <= 1'b1;
    end else begin
      state <= state_next;
      zxuno_addr <= addr_d; dout <= dout_d;
      zxuno_regwr <= regwr_d; zxuno_regrd <= regrd_d; uart_rts <= rts_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (rx_valid) state_next = is_cmd ? GET_ADDR : SEND;
      GET_ADDR:   if (rx_valid) state_next = is_write ? GET_DATA : BUS_SETUP;
                  else if (tmo == TMO_LAST) state_next = IDLE;
      GET_DATA:   if (rx_valid) state_next = BUS_SETUP;
                  else if (tmo == TMO_LAST) state_next = IDLE;
      BUS_SETUP:  state_next = BUS_STROBE;
      BUS_STROBE: if (scnt == STB_LAST) state_next = BUS_HOLD;
      BUS_HOLD:   state_next = SEND;
      SEND:       state_next = WAIT_TX;
      WAIT_TX:    if (!tx_busy) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = zxuno_addr;
    dout_d   = dout;
    regwr_d  = (state_next == BUS_STROBE) && is_write;
    regrd_d  = (state_next == BUS_STROBE) && !is_write;
    rts_d    = !(state_next inside {IDLE, GET_ADDR, GET_DATA});
    tx_start = (state == SEND);
    // the final command byte is still only in rx_sh on the cycle it arrives
    if (state_next == BUS_SETUP) begin
      addr_d = (state == GET_ADDR) ? rx_sh : addr_l;
      if (is_write) dout_d = rx_sh;
    end
  end
endmodule

// File: tb/tb_zxuno_uart_regbridge.sv
// Directed bench for zxuno_uart_regbridge at DIV=16: host frames in, bus cycles and reply bytes checked.
`timescale 1ns/1ps
module tb_zxuno_uart_regbridge;
  localparam int unsigned TMO = 1000;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] zxuno_addr, dout, din;
  logic       zxuno_regrd, zxuno_regwr, oe_n, uart_rx, uart_tx, uart_rts;

  always #5 clk = ~clk;

  zxuno_uart_regbridge #(
    .CLK_HZ(1600000), .BAUD(100000), .BUS_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .dout(dout), .din(din), .oe_n(oe_n),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_rts(uart_rts)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host-side receiver of reply bytes
  logic [7:0] tx_q[$];
  logic [7:0] txb;
  int tx_stop_bad = 0;
  initial forever begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        txb[i] = uart_tx;
      end
      repeat (16) @(negedge clk);
      if (uart_tx !== 1'b1) tx_stop_bad++;
      tx_q.push_back(txb);
    end
  end

  // Bus watcher: strobe windows, setup/hold stability, strobe exclusivity
  int wr_n = 0, rd_n = 0, setup_bad = 0, hold_bad = 0, stable_bad = 0, both_bad = 0;
  int cur_len = 0, win_len = 0;
  logic [7:0] w_addr, w_dout, last_addr, last_dout, p_addr, p_dout;
  logic p_s = 1'b0;
  always @(negedge clk) begin
    if (zxuno_regwr && zxuno_regrd) both_bad++;
    if ((zxuno_regwr || zxuno_regrd) && !p_s) begin
      cur_len = 1; w_addr = zxuno_addr; w_dout = dout;
      if (p_addr !== zxuno_addr || p_dout !== dout) setup_bad++;
      if (zxuno_regwr) wr_n++; else rd_n++;
    end else if ((zxuno_regwr || zxuno_regrd) && p_s) begin
      cur_len++;
      if (zxuno_addr !== w_addr || dout !== w_dout) stable_bad++;
    end else if (p_s) begin
      win_len = cur_len; last_addr = w_addr; last_dout = w_dout;
      if (zxuno_addr !== w_addr || dout !== w_dout) hold_bad++;
    end
    p_s = zxuno_regwr || zxuno_regrd; p_addr = zxuno_addr; p_dout = dout;
  end

  int wr0, rd0;
  logic [7:0] rep;
  logic ok, seen;

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stopb;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    wr0 = wr_n; rd0 = rd_n;
    send_frame(a, 1'b1);
    if (n > 1) send_frame(b, 1'b1);
    if (n > 2) send_frame(c, 1'b1);
  endtask

  task automatic get_reply(output logic [7:0] b, output logic got);
    got = 1'b0; b = '0;
    for (int i = 0; i < 800; i++) begin
      if (tx_q.size() > 0) begin
        b = tx_q.pop_front(); got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    uart_rx = 1'b1; din = '0; oe_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_addr", zxuno_addr, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_regrd", zxuno_regrd, 1'b0);
    check("rst_regwr", zxuno_regwr, 1'b0);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_rts", uart_rts, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rts_after_rst", uart_rts, 1'b0);

    send_cmd(8'h57, 8'hFA, 8'h41, 3); get_reply(rep, ok);
    check("w1_ok", ok, 1'b1); check("w1_reply", rep, 8'h06);
    check("w1_wr", wr_n - wr0, 1); check("w1_rd", rd_n - rd0, 0);
    check("w1_len", win_len, 2); check("w1_addr", last_addr, 8'hFA); check("w1_dout", last_dout, 8'h41);

    din = 8'h80; oe_n = 1'b0;
    send_cmd(8'h52, 8'hFB, 8'h00, 2); get_reply(rep, ok);
    check("r1_ok", ok, 1'b1); check("r1_reply", rep, 8'h80);
    check("r1_rd", rd_n - rd0, 1); check("r1_wr", wr_n - wr0, 0);
    check("r1_len", win_len, 2); check("r1_addr", last_addr, 8'hFB);

    din = 8'h5A; oe_n = 1'b1;
    send_cmd(8'h52, 8'h10, 8'h00, 2); get_reply(rep, ok);
    check("r2_ok", ok, 1'b1); check("r2_reply", rep, 8'hFF);
    check("r2_rd", rd_n - rd0, 1); check("r2_addr", last_addr, 8'h10);

    send_cmd(8'h3F, 8'h00, 8'h00, 1); get_reply(rep, ok);
    check("nak_ok", ok, 1'b1); check("nak_reply", rep, 8'h15);
    check("nak_strobes", (wr_n - wr0) + (rd_n - rd0), 0);
    send_cmd(8'h57, 8'hFA, 8'h00, 3); get_reply(rep, ok);
    check("w2_reply", rep, 8'h06); check("w2_wr", wr_n - wr0, 1); check("w2_dout", last_dout, 8'h00);

    send_cmd(8'h57, 8'hFA, 8'h00, 2);
    check("tmo_rts_wait", uart_rts, 1'b0);
    repeat (TMO + 200) @(negedge clk);
    check("tmo_no_tx", tx_q.size(), 0);
    check("tmo_no_strobe", (wr_n - wr0) + (rd_n - rd0), 0);
    check("tmo_rts", uart_rts, 1'b0);
    din = 8'h80; oe_n = 1'b0;
    send_cmd(8'h52, 8'hFB, 8'h00, 2); get_reply(rep, ok);
    check("tmo_next_reply", rep, 8'h80); check("tmo_next_rd", rd_n - rd0, 1);

    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk); uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    check("false_start", tx_q.size(), 0);

    oe_n = 1'b1; rd0 = rd_n;
    send_frame(8'h52, 1'b0);
    repeat (40) @(negedge clk);
    send_frame(8'h3F, 1'b1); get_reply(rep, ok);
    check("frame_err_reply", rep, 8'h15); check("frame_err_rd", rd_n - rd0, 0);
    check("setup_stable", setup_bad, 0);
    check("hold_stable", hold_bad, 0);
    check("strobe_stable", stable_bad, 0);

    send_frame(8'h57, 1'b1); send_frame(8'h20, 1'b1);
    seen = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (zxuno_regwr) seen = 1'b1;
        end
        if (seen) begin
          rst = 1'b1;
          @(negedge clk);
          check("abort_regwr", zxuno_regwr, 1'b0);
          check("abort_regrd", zxuno_regrd, 1'b0);
          check("abort_tx", uart_tx, 1'b1);
          check("abort_rts", uart_rts, 1'b1);
          check("abort_addr", zxuno_addr, 8'h00);
          rst = 1'b0;
        end
      end
    join
    check("abort_strobe_seen", seen, 1'b1);
    repeat (300) @(negedge clk);
    check("abort_no_tx", tx_q.size(), 0);
    check("abort_rts_back", uart_rts, 1'b0);
    send_cmd(8'h3F, 8'h00, 8'h00, 1); get_reply(rep, ok);
    check("post_abort_reply", rep, 8'h15);
    check("both_strobes", both_bad, 0);
    check("tx_stop_bits", tx_stop_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
